// File: rtl/connect4_pkg.sv
// Shared Connect4 encodings: board size, exported state, game status and player codes.
package connect4_pkg;

    localparam int ROWS = 6;
    localparam int COLS = 7;

    // 2-bit state code seen by the LED status display
    typedef enum logic [1:0] {
        GAME_INIT = 2'b00,
        P1_TURN   = 2'b01,
        P2_TURN   = 2'b10,
        END_GAME  = 2'b11
    } game_state_e;

    typedef enum logic [1:0] {
        STILL_PLAYING = 2'b00,
        P1_WINS       = 2'b01,
        P2_WINS       = 2'b10,
        TIE           = 2'b11
    } game_status_e;

    // Player codes match the win-checker result codes and the P1_WINS/P2_WINS status codes
    typedef enum logic [1:0] {
        PLAYER_NONE = 2'b00,
        PLAYER_1    = 2'b01,
        PLAYER_2    = 2'b10
    } player_e;

    // Internal sequencer states
    typedef enum logic [2:0] {
        S_INIT,
        S_TURN,
        S_WRITE,
        S_CHECK,
        S_END
    } fsm_e;

    function automatic player_e other_player(input player_e p);
        return (p == PLAYER_1) ? PLAYER_2 : PLAYER_1;
    endfunction

endpackage

// File: rtl/column_height_tracker.sv
// Per-column fill heights: one 3-bit counter per column, with an increment port,
// a synchronous clear, and the height/full flag of one selected column.
module column_height_tracker #(
    parameter int ROWS = connect4_pkg::ROWS,
    parameter int COLS = connect4_pkg::COLS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    input  logic [2:0] inc_col,
    input  logic [2:0] sel_col,
    output logic [2:0] sel_height,
    output logic       sel_full
);

    logic [2:0] height_q [COLS];

    // Counter bank: clear wins over increment; out-of-range columns are never touched
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the heights sit in plain flops rather than a RAM, so the whole array takes the async reset.
        if (!rst_n) begin
            for (int i = 0; i < COLS; i++) height_q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < COLS; i++) height_q[i] <= '0;
        end else if (inc && int'(inc_col) < COLS) begin
            // NOTE: sequential state uses <= so every flop sees the pre-edge values.
            height_q[inc_col] <= height_q[inc_col] + 3'd1;
        end
    end

    // Read port for the selected column; an out-of-range column reads as empty
    always_comb begin
        sel_height = '0;
        if (int'(sel_col) < COLS) sel_height = height_q[sel_col];
        sel_full = (sel_height == 3'(ROWS));
    end

endmodule

// File: rtl/connect4_turn_controller.sv
// Connect4 game sequencer: validates drops, issues one board write per legal move,
// runs the win-checker handshake and decides turn swap, win or tie.
module connect4_turn_controller #(
    parameter int ROWS   = connect4_pkg::ROWS,
    parameter int COLS   = connect4_pkg::COLS,
    parameter int MOVE_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              drop,
    input  logic [2:0]        col_sel,
    output logic              wr_en,
    output logic [2:0]        wr_row,
    output logic [2:0]        wr_col,
    output logic [1:0]        wr_player,
    output logic              check_req,
    input  logic              check_done,
    input  logic [1:0]        check_result,
    output logic [1:0]        state,
    output logic [1:0]        game_status,
    output logic [MOVE_W-1:0] move_count,
    output logic              illegal_move
);

    import connect4_pkg::*;

    localparam logic [MOVE_W-1:0] MAX_MOVES = MOVE_W'(ROWS * COLS);

    fsm_e              state_q, state_d;
    player_e           player_q;
    game_status_e      status_q, status_d;
    logic [2:0]        col_q;
    logic [MOVE_W-1:0] move_count_q;
    logic              illegal_q;

    logic       load_p1, toggle_player, latch_col, set_status, illegal_d, clr_game, inc_move;
    logic [2:0] sel_col, sel_height;
    logic       sel_full;

    // During the write the latched column is read; otherwise the requested column is checked
    assign sel_col = (state_q == S_WRITE) ? col_q : col_sel;

    column_height_tracker #(.ROWS(ROWS), .COLS(COLS)) u_heights (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr_game),
        .inc        (inc_move),
        .inc_col    (col_q),
        .sel_col    (sel_col),
        .sel_height (sel_height),
        .sel_full   (sel_full)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_INIT;
        else        state_q <= state_d;
    end

    // Next-state and control decode
    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch can infer a latch.
        state_d       = state_q;
        status_d      = STILL_PLAYING;
        load_p1       = 1'b0;
        toggle_player = 1'b0;
        latch_col     = 1'b0;
        set_status    = 1'b0;
        illegal_d     = 1'b0;
        clr_game      = 1'b0;
        inc_move      = 1'b0;
        case (state_q)
            S_INIT: begin
                if (start) begin
                    load_p1 = 1'b1;
                    state_d = S_TURN;
                end
            end
            S_TURN: begin
                if (drop) begin
                    if (int'(col_sel) >= COLS || sel_full) begin
                        illegal_d = 1'b1;
                    end else begin
                        latch_col = 1'b1;
                        state_d   = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                inc_move = 1'b1;
                state_d  = S_CHECK;
            end
            S_CHECK: begin
                if (check_done) begin
                    if (check_result == player_q) begin
                        set_status = 1'b1;
                        status_d   = (player_q == PLAYER_1) ? P1_WINS : P2_WINS;
                        state_d    = S_END;
                    end else if (move_count_q == MAX_MOVES) begin
                        set_status = 1'b1;
                        status_d   = TIE;
                        state_d    = S_END;
                    end else begin
                        toggle_player = 1'b1;
                        state_d       = S_TURN;
                    end
                end
            end
            S_END: begin
                if (start) begin
                    clr_game = 1'b1;
                    state_d  = S_INIT;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // Game bookkeeping: current player, latched column, move count, result and illegal pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            player_q     <= PLAYER_1;
            col_q        <= '0;
            move_count_q <= '0;
            status_q     <= STILL_PLAYING;
            illegal_q    <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
            if (latch_col) col_q <= col_sel;
            if (clr_game || load_p1) player_q <= PLAYER_1;
            else if (toggle_player)  player_q <= other_player(player_q);
            if (clr_game)      move_count_q <= '0;
            else if (inc_move) move_count_q <= move_count_q + 1'b1;
            if (clr_game)        status_q <= STILL_PLAYING;
            else if (set_status) status_q <= status_d;
        end
    end

    // Output decode: write strobe and fields only during S_WRITE, exported 2-bit state
    always_comb begin
        wr_en     = (state_q == S_WRITE);
        wr_row    = wr_en ? sel_height : 3'd0;
        wr_col    = wr_en ? col_q : 3'd0;
        wr_player = wr_en ? player_q : PLAYER_NONE;
        check_req = (state_q == S_CHECK);
        case (state_q)
            S_INIT:  state = GAME_INIT;
            S_END:   state = END_GAME;
            default: state = (player_q == PLAYER_2) ? P2_TURN : P1_TURN;
        endcase
    end

    assign game_status  = status_q;
    assign move_count   = move_count_q;
    assign illegal_move = illegal_q;

endmodule

// File: tb/tb_connect4_turn_controller.sv
// Randomized scoreboard bench for connect4_turn_controller against a game-rule model.
module tb_connect4_turn_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       drop = 1'b0;
    logic [2:0] col_sel = '0;
    logic       wr_en;
    logic [2:0] wr_row, wr_col;
    logic [1:0] wr_player;
    logic       check_req;
    logic       check_done = 1'b0;
    logic [1:0] check_result = '0;
    logic [1:0] state, game_status;
    logic [5:0] move_count;
    logic       illegal_move;

    connect4_turn_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .drop         (drop),
        .col_sel      (col_sel),
        .wr_en        (wr_en),
        .wr_row       (wr_row),
        .wr_col       (wr_col),
        .wr_player    (wr_player),
        .check_req    (check_req),
        .check_done   (check_done),
        .check_result (check_result),
        .state        (state),
        .game_status  (game_status),
        .move_count   (move_count),
        .illegal_move (illegal_move)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model of the game: board heights, whose turn, moves made, phase and result
    int h[7];
    int player;    // 1 or 2
    int mcount;
    int phase;     // 0 waiting for start, 1 playing, 2 game over
    int status;    // result code once over

    typedef struct {
        bit is_write;
        int row;
        int col;
        int player;
        int mc;
    } ev_t;
    ev_t expq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_state();
        if (phase == 0) return 0;
        if (phase == 2) return 3;
        return player;
    endfunction

    function automatic int exp_status();
        return (phase == 2) ? status : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 7; i++) h[i] = 0;
        player = 1;
        mcount = 0;
        phase  = 0;
        status = 0;
        expq.delete();
    endtask

    task automatic check_top(input string tag);
        check({tag, ".state"}, state, exp_state());
        check({tag, ".game_status"}, game_status, exp_status());
        check({tag, ".move_count"}, move_count, mcount);
    endtask

    // Monitor: every write strobe or illegal pulse must match the next expected event
    always @(negedge clk) begin
        if (rst_n && (wr_en || illegal_move)) begin
            if (expq.size() == 0) begin
                check("unexpected_event", {30'd0, wr_en, illegal_move}, 0);
            end else begin
                ev_t e;
                e = expq.pop_front();
                if (e.is_write) begin
                    check("wr_en", wr_en, 1);
                    check("wr_row", wr_row, e.row);
                    check("wr_col", wr_col, e.col);
                    check("wr_player", wr_player, e.player);
                    check("move_count_at_write", move_count, e.mc);
                    check("illegal_during_write", illegal_move, 0);
                end else begin
                    check("illegal_move", illegal_move, 1);
                    check("wr_en_on_illegal", wr_en, 0);
                end
            end
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        start = 1'b0;
        drop = 1'b0;
        check_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check_top("reset");
        check("reset.wr_en", wr_en, 0);
        check("reset.check_req", check_req, 0);
        check("reset.illegal_move", illegal_move, 0);
        check("reset.wr_fields", {wr_row, wr_col, wr_player}, 0);
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        if (phase == 0) begin
            phase  = 1;
            player = 1;
        end else if (phase == 2) begin
            for (int i = 0; i < 7; i++) h[i] = 0;
            mcount = 0;
            status = 0;
            player = 1;
            phase  = 0;
        end
        @(negedge clk);
        check_top("after_start");
    endtask

    // One drop request plus the checker response; stray pulses drop/start during the check
    task automatic do_drop(input int c, input int lat, input int res, input bit stray);
        bit legal;
        int n;
        legal = (phase == 1) && (c < 7) && (h[c] < 6);
        if (phase == 1 && !legal) expq.push_back('{0, 0, 0, 0, 0});
        if (legal) expq.push_back('{1, h[c], c, player, mcount});
        @(posedge clk); #1 drop = 1'b1; col_sel = c[2:0];
        @(posedge clk); #1 drop = 1'b0; col_sel = 3'($urandom_range(0, 7));
        if (!legal) begin
            @(negedge clk);
            check_top("after_ignored_drop");
            return;
        end
        h[c]++;
        mcount++;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (check_req) begin
                n = i + 1;
                break;
            end
        end
        check("check_req_latency", n, 2);
        if (n == 0) return;
        if (stray) begin
            @(posedge clk); #1 drop = 1'b1; start = 1'b1; col_sel = 3'($urandom_range(0, 6));
            @(posedge clk); #1 drop = 1'b0; start = 1'b0;
        end
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            check("check_req_held", check_req, 1);
            check("state_during_check", state, exp_state());
        end
        @(posedge clk); #1 check_done = 1'b1; check_result = res[1:0];
        @(posedge clk); #1 check_done = 1'b0; check_result = 2'($urandom_range(0, 3));
        if (res == player) begin
            phase  = 2;
            status = player;
        end else if (mcount == 42) begin
            phase  = 2;
            status = 3;
        end else begin
            player = 3 - player;
        end
        @(negedge clk);
        check("check_req_released", check_req, 0);
        check_top("after_check");
    endtask

    // Result the checker reports for a move that does not win: none, 11 or the opponent's code
    function automatic int non_win_result();
        int r;
        r = $urandom_range(0, 2);
        if (r == 0) return 0;
        if (r == 1) return 3;
        return 3 - player;
    endfunction

    task automatic fill_board(input bit win_last);
        int c;
        for (int m = 0; m < 42; m++) begin
            do c = $urandom_range(0, 6); while (h[c] >= 6);
            if (m == 41 && win_last) do_drop(c, $urandom_range(0, 3), player, 0);
            else                     do_drop(c, $urandom_range(0, 3), non_win_result(), 0);
        end
    endtask

    task automatic random_game();
        int c, res;
        for (int m = 0; m < 60 && phase == 1; m++) begin
            c = $urandom_range(0, 7);
            if ($urandom_range(0, 7) == 0) res = $urandom_range(1, 2);
            else                           res = non_win_result();
            do_drop(c, $urandom_range(0, 4), res, $urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        apply_reset();

        // Drop before start is ignored; then the first move of a game
        do_drop(2, 1, 0, 0);
        do_start();
        do_drop(3, 2, 0, 0);

        // Column 0 fills after six moves; a seventh and an out-of-range column are rejected
        apply_reset();
        do_start();
        for (int i = 0; i < 6; i++) do_drop(0, 1, 0, 0);
        do_drop(0, 1, 0, 0);
        do_drop(7, 1, 0, 0);

        // Stray check_done and start while waiting for a drop change nothing
        @(posedge clk); #1 check_done = 1'b1; check_result = player[1:0];
        @(posedge clk); #1 check_done = 1'b0;
        @(negedge clk);
        check_top("stray_check_done");
        check("stray_check_done.check_req", check_req, 0);
        do_start();

        // Slow checker with stray drop/start during the check, then a win
        do_drop(1, 20, 0, 1);
        do_drop(2, 1, player, 0);
        do_drop(4, 1, 0, 0);
        do_start();
        do_start();
        do_drop(0, 1, 0, 0);

        // Asynchronous reset in the middle of a check
        do_drop(5, 1, 0, 0);
        expq.push_back('{1, h[6], 6, player, mcount});
        @(posedge clk); #1 drop = 1'b1; col_sel = 3'd6;
        @(posedge clk); #1 drop = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset.check_req", check_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset.state", state, 0);
        check("async_reset.status_count", {game_status, move_count}, 0);
        check("async_reset.strobes", {wr_en, check_req, illegal_move}, 0);
        check("async_reset.wr_fields", {wr_row, wr_col, wr_player}, 0);
        apply_reset();

        // Full board, no winner: tie
        do_start();
        fill_board(0);
        do_drop(3, 1, 0, 0);
        do_start();

        // Full board where the last move also wins: the mover wins, not a tie
        do_start();
        fill_board(1);
        do_start();

        // Random games including illegal columns and assorted checker codes
        for (int g = 0; g < 4; g++) begin
            do_start();
            random_game();
            if (phase == 2) do_start();
            else apply_reset();
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/connect4_turn_controller.md
Name: connect4_turn_controller

Overview:
- Central game sequencer for Connect4.
- Accepts player drop requests, tracks per-column fill height, and issues one board write per legal move.
- Hands each move to the win-checker through a req/done handshake, then decides whether to swap turns, declare a winner or declare a tie.
- Drives the 2-bit state / game_status pair consumed by the LED status display.

Parameters:
- ROWS, 6, board rows; a column is full at height == ROWS.
- COLS, 7, board columns; legal col_sel range is 0..COLS-1.
- MOVE_W, 6, move_count width; must hold ROWS*COLS (42).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse (debounced upstream); begins a game or clears a finished one.
- drop  in  1  single-cycle pulse; current player drops a disc in col_sel.
- col_sel  in  3  target column of drop.
- wr_en  out  1  single-cycle board write strobe.
- wr_row  out  3  row written (0 = bottom).
- wr_col  out  3  column written.
- wr_player  out  2  01 = P1, 10 = P2.
- check_req  out  1  level request to win-checker.
- check_done  in  1  single-cycle completion from win-checker.
- check_result  in  2  00 none, 01 P1 wins, 10 P2 wins; 11 is treated as none.
- state  out  2  GAME_INIT=00, P1_TURN=01, P2_TURN=10, END_GAME=11.
- game_status  out  2  STILL_PLAYING=00, P1_WINS=01, P2_WINS=10, TIE=11.
- move_count  out  MOVE_W  legal moves committed this game.
- illegal_move  out  1  single-cycle pulse on a rejected drop.

Behaviour:
- Reset (asynchronous, any time, including mid-write or mid-check):
  - FSM goes to S_INIT; player = P1.
  - All column heights = 0; move_count = 0.
  - state = 00, game_status = 00.
  - wr_en, check_req and illegal_move = 0; wr_row, wr_col and wr_player = 0.
- Internal FSM: S_INIT, S_TURN, S_WRITE, S_CHECK, S_END.
- Exported state:
  - S_INIT gives 00.
  - S_TURN, S_WRITE and S_CHECK give 01 or 10 according to the current player.
  - S_END gives 11.
- S_INIT: start moves to S_TURN with player = P1. drop is ignored.
- S_TURN, on drop:
  - Illegal if col_sel >= COLS or height[col_sel] == ROWS. illegal_move pulses the next cycle; state, heights and player are unchanged.
  - Legal: latch the column and go to S_WRITE.
- S_WRITE (exactly 1 cycle):
  - wr_en = 1, wr_row = height[col], wr_col = col, wr_player = player.
  - height[col] and move_count increment at the end of the cycle.
  - Go to S_CHECK.
- S_CHECK:
  - check_req is held high from the first S_CHECK cycle until check_done is sampled high; it deasserts the cycle after.
  - On check_done, if check_result equals the current player: go to S_END with game_status = that player.
  - Otherwise, if move_count == ROWS*COLS: go to S_END with game_status = TIE.
  - Otherwise: toggle player and go to S_TURN.
  - Win takes priority over tie on the 42nd move.
  - A check_result equal to the opponent is treated as none.
- S_END: start clears heights, move_count and game_status to 0 and sets player = P1, all in one cycle, then goes to S_INIT. drop is ignored.
- Ignored inputs:
  - start in S_TURN, S_WRITE and S_CHECK is ignored.
  - drop in S_WRITE, S_CHECK and S_END is ignored; no illegal_move pulse.
  - check_done outside S_CHECK is ignored.
- Simultaneous start and drop: in S_INIT and S_END only start acts; in S_TURN only drop acts.
- Latency, drop to wr_en: 1 cycle. Drop to next turn: 2 cycles plus the checker latency.
- game_status is 00 in every state except S_END.

Decomposition:
- Shared package connect4_pkg holds:
  - STATE encodings (GAME_INIT/P1_TURN/P2_TURN/END_GAME).
  - GAME_STATUS encodings (STILL_PLAYING/P1_WINS/P2_WINS/TIE).
  - Player codes.
  - ROWS and COLS.
- The LED display and the win-checker import the same package.
- One sub-module, column_height_tracker:
  - Holds COLS counters of 3 bits.
  - Has an increment port, a synchronous clear and a full flag for the selected column.
  - The FSM stays in the top module.

Test Plan:
- Reset, start, drop col 3, checker returns 00 after 2 cycles -> wr_en 1 cycle with row 0 / col 3 / player 01; state goes 00 to 01 to 10; move_count = 1.
- 6 alternating drops into col 0, then a 7th drop into col 0 -> illegal_move pulses once; move_count stays 6; state unchanged; wr_en never asserts. Separately, drop with col_sel = 7 -> illegal_move pulses.
- P1 move with the checker returning 01 -> state = 11, game_status = 01; later drops ignored. Start -> state = 00, move_count = 0, all heights 0.
- Fill all 42 cells with the checker always returning 00 -> after the 42nd check, state = 11, game_status = 11. Repeat with the 42nd check returning the mover's code -> that player wins, not TIE.
- Hold check_done low for 20 cycles -> check_req stays high and state stays on the current player. Assert rst_n low mid-check -> all outputs reset immediately, asynchronously.
- Pulse start during S_TURN and drop during S_CHECK -> no effect; check_done pulsed in S_TURN -> ignored.
